rec_fn_to_fn_pipe: RTL and testbench
====================================

Name: rec_fn_to_fn_pipe

Overview:
- Two-stage pipelined converter from HardFloat recoded format (recFN, 65-bit for double) back to IEEE-754 binary format (64-bit). It is the reverse of the raw-to-recoded rounding path used by the FPU result writeback.
- Feeds FP store data and FP-to-integer register moves (fmv.x.d, fsd) from the recoded FP register file.
- Uses a valid/ready handshake with full throughput and a pass-through tag.

Parameters:
- EXP_W, 11, IEEE exponent width; the recoded exponent is EXP_W+1 bits.
- SIG_W, 53, significand width including the hidden bit; the fraction is SIG_W-1 bits.
- TAG_W, 5, width of the opaque tag carried alongside the data.

Ports:
- clock  in  1  single clock, all state on the rising edge.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  1  input beat present.
- io_in_ready  out  1  block accepts the beat this cycle.
- io_in_bits_rec  in  EXP_W+SIG_W+1  recoded value: {sign, exp[EXP_W:0], fract[SIG_W-2:0]}.
- io_in_bits_tag  in  TAG_W  opaque tag.
- io_out_valid  out  1  output beat present.
- io_out_ready  in  1  consumer accepts the beat.
- io_out_bits_fn  out  EXP_W+SIG_W  IEEE value: {sign, exp[EXP_W-1:0], fract}.
- io_out_bits_tag  out  TAG_W  tag of the beat.
- io_out_bits_isSNaN  out  1  input was a signalling NaN (NaN with fract MSB = 0).

Behaviour:
- Reset (synchronous, active-high): both stage valids clear. io_out_valid=0; io_in_ready=1 from the first cycle after reset. Data registers are don't-care. Reset mid-operation discards in-flight beats with no output.
- Decode, with e = rec exp field, BIAS = 2^(EXP_W-1)+1 (1025 for doubles), MINNORM = BIAS+1 (1026):
  - isZero = e[EXP_W:EXP_W-2]==0.
  - isSpecial = e[EXP_W:EXP_W-1]==2'b11.
  - isNaN = isSpecial & e[EXP_W-2].
  - isInf = isSpecial & ~e[EXP_W-2].
  - isSub = ~isZero & ~isSpecial & (e < MINNORM).
- Output fields:
  - sign: always passed through, including zero and NaN.
  - Zero: exp=0, fract=0.
  - Inf: exp=all-ones, fract=0.
  - NaN: exp=all-ones, fract = input fract unchanged (payload preserved, no quieting); isSNaN = ~fract[SIG_W-2].
  - Normal: exp = e - BIAS (low EXP_W bits), fract = input fract.
  - Subnormal: exp=0, fract = ({1'b1, fract} >> k)[SIG_W-2:0] with k = MINNORM - e. If k >= SIG_W, fract=0 (saturate; never wrap the shift amount).
- Stage 1 registers: class flags, sign, fract, normal exponent, and shift amount k (clamped to SIG_W), plus the tag.
- Stage 2 registers: shifted fract and the assembled IEEE word, plus the tag. Outputs come directly from stage-2 registers; no combinational path from io_in to io_out.
- Latency: exactly 2 cycles from accept (io_in_valid & io_in_ready) to io_out_valid when not stalled. Throughput: 1 beat per cycle.
- Flow control:
  - s2_adv = ~s2_valid | io_out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - io_in_ready = s1_adv.
  - io_in_ready depends combinationally on io_out_ready (no skid buffer); this is intended.
- Stalls: with io_out_ready=0 and both stages full, io_in_ready=0 and all registers hold. io_out_bits_* stay stable while io_out_valid=1 and io_out_ready=0.
- Bubbles: a stage-1 bubble never blocks stage 2. Stage 2 drains even if stage 1 is empty.
- Simultaneous events: accept and emit in the same cycle are allowed; no beat is lost or duplicated. Beats leave in order.
- Tag: passes through unmodified, aligned with its data.
- isSNaN: 0 for every non-NaN beat.

Test Plan:
- Recoded 1.0: rec=65'h0_8000_0000_0000_0000, tag=3, io_out_ready=1 -> after 2 cycles fn=64'h3FF0_0000_0000_0000, tag=3, isSNaN=0.
- Specials: -Inf rec=65'h1_C000_0000_0000_0000 -> 64'hFFF0_0000_0000_0000. qNaN rec=65'h0_E008_0000_0000_0000 -> 64'h7FF8_0000_0000_0000, isSNaN=0. sNaN rec=65'h0_E000_0000_0000_0001 -> 64'h7FF0_0000_0000_0001, isSNaN=1. -0 rec=65'h1_0000_0000_0000_0000 -> 64'h8000_0000_0000_0000.
- Subnormals:
  - Smallest: rec exp=974 (12'h3CE), fract 0 -> 64'h0000_0000_0000_0001.
  - Largest-exponent: rec exp=1025, fract 0 -> 64'h0008_0000_0000_0000.
  - Min normal: rec exp=1026 -> 64'h0010_0000_0000_0000.
- Back-to-back 16 beats with io_out_ready=1 -> 16 outputs on consecutive cycles, in order, tags 0..15, io_in_ready stays 1.
- Backpressure: hold io_out_ready=0 after 2 accepts -> io_in_ready=0 next cycle, outputs stable for 10 cycles. Release -> both beats drain in order, no loss or duplication. Random valid/ready toggling over 10k beats -> scoreboard matches a reference conversion model.
- Assert reset while both stages are full -> io_out_valid=0 the next cycle. The post-reset beat emerges alone, 2 cycles after it is accepted.

Source files
------------

// File: rtl/rec_fn_to_fn_pipe.sv
// rec_fn_to_fn_pipe: two-stage recoded-float to IEEE-754 converter with valid/ready flow control
module rec_fn_to_fn_pipe #(
  parameter int EXP_W = 11,
  parameter int SIG_W = 53,
  parameter int TAG_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [EXP_W+SIG_W:0]   io_in_bits_rec,
  input  logic [TAG_W-1:0]       io_in_bits_tag,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [EXP_W+SIG_W-1:0] io_out_bits_fn,
  output logic [TAG_W-1:0]       io_out_bits_tag,
  output logic                   io_out_bits_isSNaN
);
  localparam int KW = $clog2(SIG_W + 1);
  localparam int BIAS_I = 2 ** (EXP_W - 1) + 1;
  localparam logic [EXP_W-1:0] BIAS_L = EXP_W'(BIAS_I);
  localparam logic [EXP_W:0] MINNORM = (EXP_W + 1)'(BIAS_I + 1);
  localparam logic [EXP_W:0] SIG_E = (EXP_W + 1)'(SIG_W);
  localparam logic [KW-1:0] SIG_K = KW'(SIG_W);

  logic inSign, inZero, inSpecial, inNaN, inInf, inSub;
  logic [EXP_W:0] inExp, kDiff;
  logic [SIG_W-2:0] inFract;
  logic [EXP_W-1:0] inNormExp;
  logic [KW-1:0] inK;

  logic s1Valid, s1Sign, s1Zero, s1Inf, s1NaN, s1Sub;
  logic [SIG_W-2:0] s1Fract;
  logic [EXP_W-1:0] s1Exp;
  logic [KW-1:0] s1K;
  logic [TAG_W-1:0] s1Tag;

  logic s2Valid, s2SNaN;
  logic [EXP_W+SIG_W-1:0] s2Fn;
  logic [TAG_W-1:0] s2Tag;

  logic s1Adv, s2Adv;
  logic [SIG_W-2:0] subFract, fnFract;
  logic [EXP_W-1:0] fnExp;

  always_comb begin
    inSign    = io_in_bits_rec[EXP_W+SIG_W];
    inExp     = io_in_bits_rec[EXP_W+SIG_W-1 -: EXP_W+1];
    inFract   = io_in_bits_rec[SIG_W-2:0];
    inZero    = inExp[EXP_W -: 3] == 3'b000;
    inSpecial = &inExp[EXP_W -: 2];
    inNaN     = inSpecial & inExp[EXP_W-2];
    inInf     = inSpecial & ~inExp[EXP_W-2];
    inSub     = ~inZero & ~inSpecial & (inExp < MINNORM);
    inNormExp = inExp[EXP_W-1:0] - BIAS_L;
    kDiff     = MINNORM - inExp;
    // Clamp before registering so deep subnormals can never wrap the shifter
    inK       = (kDiff >= SIG_E) ? SIG_K : kDiff[KW-1:0];
  end

  always_comb begin
    subFract = (s1K >= SIG_K) ? '0 : (SIG_W - 1)'({1'b1, s1Fract} >> s1K);
    fnExp    = (s1Zero | s1Sub) ? '0 : (s1Inf | s1NaN) ? '1 : s1Exp;
    fnFract  = (s1Zero | s1Inf) ? '0 : s1Sub ? subFract : s1Fract;
  end

  assign s2Adv = ~s2Valid | io_out_ready;
  assign s1Adv = ~s1Valid | s2Adv;
  assign io_in_ready = s1Adv;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      if (s1Adv) s1Valid <= io_in_valid;
      if (s2Adv) s2Valid <= s1Valid;
    end
    if (s1Adv) begin
      s1Sign  <= inSign;
      s1Zero  <= inZero;
      s1Inf   <= inInf;
      s1NaN   <= inNaN;
      s1Sub   <= inSub;
      s1Fract <= inFract;
      s1Exp   <= inNormExp;
      s1K     <= inK;
      s1Tag   <= io_in_bits_tag;
    end
    if (s2Adv) begin
      s2Fn   <= {s1Sign, fnExp, fnFract};
      s2SNaN <= s1NaN & ~s1Fract[SIG_W-2];
      s2Tag  <= s1Tag;
    end
  end

  assign io_out_valid       = s2Valid;
  assign io_out_bits_fn     = s2Fn;
  assign io_out_bits_tag    = s2Tag;
  assign io_out_bits_isSNaN = s2SNaN;
endmodule

// File: tb/tb_rec_fn_to_fn_pipe.sv
// tb_rec_fn_to_fn_pipe: directed and randomized checks of the recoded-to-IEEE pipeline
module tb_rec_fn_to_fn_pipe;
  logic clock, reset, inValid, inReady, outValid, outReady, outSNaN;
  logic [64:0] inRec;
  logic [4:0] inTag, outTag;
  logic [63:0] outFn;
  int tests = 0;
  int fails = 0;

  rec_fn_to_fn_pipe dut (
    .clock(clock), .reset(reset),
    .io_in_valid(inValid), .io_in_ready(inReady),
    .io_in_bits_rec(inRec), .io_in_bits_tag(inTag),
    .io_out_valid(outValid), .io_out_ready(outReady),
    .io_out_bits_fn(outFn), .io_out_bits_tag(outTag),
    .io_out_bits_isSNaN(outSNaN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [69:0] model(input logic [64:0] r, input logic [4:0] t);
    logic s;
    logic [11:0] e;
    logic [51:0] f;
    logic [52:0] m;
    logic [63:0] fn;
    logic sn;
    int k;
    s = r[64];
    e = r[63:52];
    f = r[51:0];
    sn = 1'b0;
    if (e[11:9] == 3'b000) fn = {s, 63'd0};
    else if (e[11:10] == 2'b11) begin
      fn = {s, 11'h7FF, e[9] ? f : 52'd0};
      sn = e[9] & ~f[51];
    end else if (int'(e) < 1026) begin
      k = 1026 - int'(e);
      m = {1'b1, f};
      fn = {s, 11'd0, (k >= 53) ? 52'd0 : 52'(m >> k)};
    end else fn = {s, 11'(int'(e) - 1025), f};
    return {t, sn, fn};
  endfunction

  task automatic run_vec(input string name, input logic [64:0] rec, input logic [4:0] tag,
                         input logic [63:0] expFn, input logic expSNaN);
    @(posedge clock); #1;
    inValid = 1'b1; inRec = rec; inTag = tag; outReady = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(negedge clock);
    tests++;
    if (outValid !== 1'b0) begin fails++; $display("FAIL %s early: out_valid=%b want 0", name, outValid); end
    @(negedge clock);
    tests++;
    if (outValid !== 1'b1) begin fails++; $display("FAIL %s latency: out_valid=%b want 1", name, outValid); end
    tests++;
    if (outFn !== expFn) begin fails++; $display("FAIL %s fn: got %h want %h", name, outFn, expFn); end
    tests++;
    if (outTag !== tag) begin fails++; $display("FAIL %s tag: got %0d want %0d", name, outTag, tag); end
    tests++;
    if (outSNaN !== expSNaN) begin fails++; $display("FAIL %s isSNaN: got %b want %b", name, outSNaN, expSNaN); end
    @(negedge clock);
    tests++;
    if (outValid !== 1'b0) begin fails++; $display("FAIL %s duplicate: out_valid=%b want 0", name, outValid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; inRec = '0; inTag = '0; outReady = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    tests++;
    if (outValid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", outValid); end
    tests++;
    if (inReady !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", inReady); end
  endtask

  task automatic test_normal();
    run_vec("one", 65'h0_8000_0000_0000_0000, 5'd3, 64'h3FF0_0000_0000_0000, 1'b0);
    run_vec("maxnorm", {1'b0, 12'hBFF, 52'hF_FFFF_FFFF_FFFF}, 5'd4, 64'h7FEF_FFFF_FFFF_FFFF, 1'b0);
  endtask

  task automatic test_specials();
    run_vec("neginf", 65'h1_C000_0000_0000_0000, 5'd5, 64'hFFF0_0000_0000_0000, 1'b0);
    run_vec("qnan", 65'h0_E008_0000_0000_0000, 5'd6, 64'h7FF8_0000_0000_0000, 1'b0);
    run_vec("snan", 65'h0_E000_0000_0000_0001, 5'd7, 64'h7FF0_0000_0000_0001, 1'b1);
    run_vec("negzero", 65'h1_0000_0000_0000_0000, 5'd8, 64'h8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_subnormal();
    run_vec("sub_min", {1'b0, 12'd974, 52'd0}, 5'd9, 64'h0000_0000_0000_0001, 1'b0);
    run_vec("sub_max", {1'b0, 12'd1025, 52'd0}, 5'd10, 64'h0008_0000_0000_0000, 1'b0);
    run_vec("minnorm", {1'b0, 12'd1026, 52'd0}, 5'd11, 64'h0010_0000_0000_0000, 1'b0);
    run_vec("sub_k2", {1'b0, 12'd1024, 52'hF_FFFF_FFFF_FFFF}, 5'd12, 64'h0007_FFFF_FFFF_FFFF, 1'b0);
    run_vec("sub_k53", {1'b0, 12'd973, 52'hF_FFFF_FFFF_FFFF}, 5'd13, 64'h0000_0000_0000_0000, 1'b0);
    run_vec("sub_deep", {1'b1, 12'd512, 52'h1_2345_6789_ABCD}, 5'd14, 64'h8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int j;
    logic [63:0] expFn;
    for (int c = 0; c < 19; c++) begin
      @(posedge clock); #1;
      outReady = 1'b1;
      inValid = c < 16;
      inRec = {1'b0, 12'(2048 + c), 52'(c * 3 + 1)};
      inTag = 5'(c);
      @(negedge clock);
      if (c < 16) begin
        tests++;
        if (inReady !== 1'b1) begin fails++; $display("FAIL b2b in_ready cycle %0d: got %b want 1", c, inReady); end
      end
      tests++;
      if (outValid !== (c >= 2 && c <= 17)) begin
        fails++; $display("FAIL b2b out_valid cycle %0d: got %b want %b", c, outValid, c >= 2 && c <= 17);
      end
      if (c >= 2 && c <= 17) begin
        j = c - 2;
        expFn = {1'b0, 11'(1023 + j), 52'(j * 3 + 1)};
        tests++;
        if (outFn !== expFn || outTag !== 5'(j)) begin
          fails++; $display("FAIL b2b beat %0d: got %h/%0d want %h/%0d", j, outFn, outTag, expFn, j);
        end
      end
    end
    #1 inValid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(posedge clock); #1;
    outReady = 1'b0; inValid = 1'b1; inRec = 65'h0_8000_0000_0000_0000; inTag = 5'd7;
    @(posedge clock); #1;
    inRec = 65'h1_C000_0000_0000_0000; inTag = 5'd8;
    @(negedge clock);
    tests++;
    if (inReady !== 1'b1) begin fails++; $display("FAIL bp second accept: in_ready=%b want 1", inReady); end
    @(posedge clock); #1;
    inValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      tests++;
      if (inReady !== 1'b0 || outValid !== 1'b1 || outFn !== 64'h3FF0_0000_0000_0000 || outTag !== 5'd7) begin
        fails++;
        $display("FAIL bp hold %0d: ready=%b valid=%b fn=%h tag=%0d want 0/1/3ff0000000000000/7",
                 c, inReady, outValid, outFn, outTag);
      end
      @(posedge clock); #1;
    end
    outReady = 1'b1;
    @(negedge clock);
    tests++;
    if (outValid !== 1'b1 || outFn !== 64'h3FF0_0000_0000_0000 || outTag !== 5'd7) begin
      fails++; $display("FAIL bp drain A: valid=%b fn=%h tag=%0d want 1/3ff0000000000000/7", outValid, outFn, outTag);
    end
    @(negedge clock);
    tests++;
    if (outValid !== 1'b1 || outFn !== 64'hFFF0_0000_0000_0000 || outTag !== 5'd8) begin
      fails++; $display("FAIL bp drain B: valid=%b fn=%h tag=%0d want 1/fff0000000000000/8", outValid, outFn, outTag);
    end
    @(negedge clock);
    tests++;
    if (outValid !== 1'b0) begin fails++; $display("FAIL bp empty: out_valid=%b want 0", outValid); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clock); #1;
    outReady = 1'b0; inValid = 1'b1; inRec = 65'h0_8000_0000_0000_0000; inTag = 5'd1;
    @(posedge clock); #1;
    inTag = 5'd2;
    @(posedge clock); #1;
    inValid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; outReady = 1'b1;
    @(negedge clock);
    tests++;
    if (outValid !== 1'b0) begin fails++; $display("FAIL midreset out_valid: got %b want 0", outValid); end
    run_vec("post_reset", 65'h0_8000_0000_0000_0000, 5'd9, 64'h3FF0_0000_0000_0000, 1'b0);
  endtask

  task automatic test_random();
    logic [69:0] q[$];
    logic [69:0] expW;
    logic [11:0] e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      @(posedge clock); #1;
      case ($urandom_range(0, 5))
        0: e = 12'($urandom_range(0, 511));
        1: e = 12'($urandom_range(3072, 4095));
        2: e = 12'($urandom_range(960, 1026));
        3: e = 12'($urandom_range(512, 960));
        default: e = 12'($urandom_range(1026, 3071));
      endcase
      inRec = {1'($urandom), e, 20'($urandom), 32'($urandom)};
      inTag = 5'(sent);
      inValid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      outReady = $urandom_range(0, 3) != 0;
      @(negedge clock);
      if (inValid && inReady) begin
        q.push_back(model(inRec, inTag));
        sent++;
      end
      if (outValid && outReady) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand spurious beat: got %h/%0d want none", outFn, outTag);
        end else begin
          expW = q.pop_front();
          if ({outTag, outSNaN, outFn} !== expW) begin
            fails++;
            $display("FAIL rand beat %0d: got tag=%0d snan=%b fn=%h want tag=%0d snan=%b fn=%h",
                     got, outTag, outSNaN, outFn, expW[69:65], expW[64], expW[63:0]);
          end
        end
        got++;
      end
      cyc++;
    end
    tests++;
    if (got < 10000) begin fails++; $display("FAIL rand timeout: got %0d beats want 10000", got); end
    #1 inValid = 1'b0; outReady = 1'b1;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
